// File: rtl/gray_area_package.sv
// Codeword layout helpers: where each payload bit lands in the 1-based codeword,
// and which payload bits feed each parity bit.
package gray_area_package;

    localparam int MAX_DATA_WIDTH = 64;

    // Position of payload bit idx, skipping the power-of-two slots that hold parity.
    function automatic int data_pos(input int idx);
        int pos;
        int seen;
        pos  = 0;
        seen = -1;
        for (int p = 1; p < 128; p++) begin
            if ((p & (p - 1)) != 0) begin
                seen++;
                if (seen == idx && pos == 0) begin
                    pos = p;
                end
            end
        end
        return pos;
    endfunction

    // Payload bits whose codeword position has bit i set.
    function automatic logic [MAX_DATA_WIDTH-1:0] parity_mask(input int dw, input int i);
        logic [MAX_DATA_WIDTH-1:0] mask;
        mask = '0;
        for (int j = 0; j < MAX_DATA_WIDTH; j++) begin
            if (j < dw && ((data_pos(j) >> i) & 1) == 1) begin
                mask[j] = 1'b1;
            end
        end
        return mask;
    endfunction

endpackage

// File: rtl/hamming_defines.svh
// Shared Hamming geometry: number of parity bits and total codeword width for a given payload width.
// Closed form of the smallest r with 2^r >= dw + r + 1, valid for payload widths 4..57.
`ifndef HAMMING_DEFINES_SVH
`define HAMMING_DEFINES_SVH

`define HAMMING_CODE_BITS(dw) (((dw) <= 4) ? 3 : ((dw) <= 11) ? 4 : ((dw) <= 26) ? 5 : 6)
`define HAMMING_CODED_WIDTH(dw) ((dw) + `HAMMING_CODE_BITS(dw))

`endif

// File: rtl/hamming_encoder.sv
// Hamming parity encoder: registers the accepted payload together with its even parity bits.
// Latency 1 cycle, one result per cycle; no backpressure, every valid input is accepted.
`include "hamming_defines.svh"

module hamming_encoder
    import gray_area_package::*;
#(
    parameter int DATA_WIDTH = 8
) (
    input  logic                                      clk_i,
    input  logic                                      rst_n_i,
    input  logic [DATA_WIDTH-1:0]                     data_in_i,
    input  logic                                      valid_in_i,
    output logic [DATA_WIDTH-1:0]                     data_out_o,
    output logic [`HAMMING_CODE_BITS(DATA_WIDTH)-1:0] parity_bits_o,
    output logic                                      valid_out_o
);

    localparam int CODE_BITS   = `HAMMING_CODE_BITS(DATA_WIDTH);
    localparam int CODED_WIDTH = `HAMMING_CODED_WIDTH(DATA_WIDTH);

    logic [DATA_WIDTH-1:0] data_d,   data_q;
    logic [CODE_BITS-1:0]  parity_d, parity_q;
    logic [CODE_BITS-1:0]  parity_comb;
    logic                  valid_d,  valid_q;

    // One parity term per power-of-two codeword position.
    for (genvar i = 0; i < CODE_BITS; i++) begin : g_parity
        localparam logic [MAX_DATA_WIDTH-1:0] MASK_FULL = parity_mask(DATA_WIDTH, i);
        localparam logic [DATA_WIDTH-1:0]     MASK      = MASK_FULL[DATA_WIDTH-1:0];
        assign parity_comb[i] = ^(data_in_i & MASK);
    end

    always_comb begin
        data_d   = data_q;
        parity_d = parity_q;
        valid_d  = valid_in_i;
        if (valid_in_i) begin
            data_d   = data_in_i;
            parity_d = parity_comb;
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            data_q   <= '0;
            parity_q <= '0;
            valid_q  <= 1'b0;
        end else begin
            data_q   <= data_d;
            parity_q <= parity_d;
            valid_q  <= valid_d;
        end
    end

    assign data_out_o    = data_q;
    assign parity_bits_o = parity_q;
    assign valid_out_o   = valid_q;

endmodule

// File: tb/tb_hamming_encoder.sv
// Directed bench for hamming_encoder at DATA_WIDTH=8: reset, known parities, streaming,
// hold behaviour, asynchronous reset and single-bit-error syndromes on random payloads.
module tb_hamming_encoder;

    logic       clk_i = 1'b0;
    logic       rst_n_i;
    logic [7:0] data_in_i;
    logic       valid_in_i;
    logic [7:0] data_out_o;
    logic [3:0] parity_bits_o;
    logic       valid_out_o;

    int n_checks = 0;
    int n_fail   = 0;

    hamming_encoder #(.DATA_WIDTH(8)) dut (
        .clk_i        (clk_i),
        .rst_n_i      (rst_n_i),
        .data_in_i    (data_in_i),
        .valid_in_i   (valid_in_i),
        .data_out_o   (data_out_o),
        .parity_bits_o(parity_bits_o),
        .valid_out_o  (valid_out_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [3:0] ref_parity(input logic [7:0] d);
        logic [3:0] p;
        p[0] = d[0] ^ d[1] ^ d[3] ^ d[4] ^ d[6];
        p[1] = d[0] ^ d[2] ^ d[3] ^ d[5] ^ d[6];
        p[2] = d[1] ^ d[2] ^ d[3] ^ d[7];
        p[3] = d[4] ^ d[5] ^ d[6] ^ d[7];
        return p;
    endfunction

    // Single accepted word: drive on the falling edge, sample 1 ns after the rising edge.
    task automatic send_one(input logic [7:0] d);
        @(negedge clk_i);
        valid_in_i = 1'b1;
        data_in_i  = d;
        @(posedge clk_i);
        #1;
        valid_in_i = 1'b0;
    endtask

    logic [7:0]  vec_dat [5];
    logic [3:0]  vec_par [5];
    logic [7:0]  seq_dat [3];
    logic [3:0]  seq_par [3];
    logic [12:0] cw;
    logic [12:0] err;
    logic [3:0]  syn;
    logic [7:0]  rnd;

    initial begin
        vec_dat = '{8'h00, 8'hFF, 8'h01, 8'h80, 8'h10};
        vec_par = '{4'b0000, 4'b0011, 4'b0011, 4'b1100, 4'b1001};
        seq_dat = '{8'h01, 8'h80, 8'h10};
        seq_par = '{4'b0011, 4'b1100, 4'b1001};

        rst_n_i    = 1'b0;
        valid_in_i = 1'b0;
        data_in_i  = 8'hA5;
        #12;
        check_eq("reset_valid",  {31'd0, valid_out_o}, 32'd0);
        check_eq("reset_data",   {24'd0, data_out_o}, 32'd0);
        check_eq("reset_parity", {28'd0, parity_bits_o}, 32'd0);
        @(negedge clk_i);
        rst_n_i = 1'b1;

        for (int v = 0; v < 5; v++) begin
            send_one(vec_dat[v]);
            check_eq($sformatf("dir%0d_valid", v), {31'd0, valid_out_o}, 32'd1);
            check_eq($sformatf("dir%0d_data", v), {24'd0, data_out_o}, {24'd0, vec_dat[v]});
            check_eq($sformatf("dir%0d_parity", v), {28'd0, parity_bits_o}, {28'd0, vec_par[v]});
            @(posedge clk_i);
            #1;
            check_eq($sformatf("dir%0d_strobe_drop", v), {31'd0, valid_out_o}, 32'd0);
        end

        // Back-to-back stream: new input set right after each edge.
        @(negedge clk_i);
        valid_in_i = 1'b1;
        data_in_i  = seq_dat[0];
        for (int s = 0; s < 3; s++) begin
            @(posedge clk_i);
            #1;
            check_eq($sformatf("b2b%0d_valid", s), {31'd0, valid_out_o}, 32'd1);
            check_eq($sformatf("b2b%0d_data", s), {24'd0, data_out_o}, {24'd0, seq_dat[s]});
            check_eq($sformatf("b2b%0d_parity", s), {28'd0, parity_bits_o}, {28'd0, seq_par[s]});
            if (s < 2) data_in_i = seq_dat[s+1];
            else       valid_in_i = 1'b0;
        end

        for (int h = 0; h < 4; h++) begin
            data_in_i = 8'(h * 8'h3B + 8'h5C);
            @(posedge clk_i);
            #1;
            check_eq($sformatf("hold%0d_valid", h), {31'd0, valid_out_o}, 32'd0);
            check_eq($sformatf("hold%0d_data", h), {24'd0, data_out_o}, 32'h10);
            check_eq($sformatf("hold%0d_parity", h), {28'd0, parity_bits_o}, 32'h9);
        end

        for (int r = 0; r < 8; r++) begin
            rnd = 8'($urandom);
            send_one(rnd);
            check_eq($sformatf("rnd%0d_valid", r), {31'd0, valid_out_o}, 32'd1);
            check_eq($sformatf("rnd%0d_data", r), {24'd0, data_out_o}, {24'd0, rnd});
            check_eq($sformatf("rnd%0d_parity", r), {28'd0, parity_bits_o}, {28'd0, ref_parity(rnd)});
            cw = '0;
            cw[1]  = parity_bits_o[0];
            cw[2]  = parity_bits_o[1];
            cw[4]  = parity_bits_o[2];
            cw[8]  = parity_bits_o[3];
            cw[3]  = data_out_o[0];
            cw[5]  = data_out_o[1];
            cw[6]  = data_out_o[2];
            cw[7]  = data_out_o[3];
            cw[9]  = data_out_o[4];
            cw[10] = data_out_o[5];
            cw[11] = data_out_o[6];
            cw[12] = data_out_o[7];
            for (int k = 0; k <= 12; k++) begin
                err = cw;
                if (k > 0) err[k] = ~err[k];
                syn = '0;
                for (int p = 1; p <= 12; p++) begin
                    if (err[p]) syn = syn ^ 4'(p);
                end
                check_eq($sformatf("rnd%0d_syndrome_flip%0d", r, k), {28'd0, syn}, k);
            end
        end

        // Asynchronous reset in the middle of a valid_out cycle.
        send_one(8'hFF);
        check_eq("arst_pre_valid", {31'd0, valid_out_o}, 32'd1);
        #2;
        rst_n_i = 1'b0;
        #1;
        check_eq("arst_valid",  {31'd0, valid_out_o}, 32'd0);
        check_eq("arst_data",   {24'd0, data_out_o}, 32'd0);
        check_eq("arst_parity", {28'd0, parity_bits_o}, 32'd0);

        // Input presented on the first edge after release is accepted.
        @(negedge clk_i);
        rst_n_i    = 1'b1;
        valid_in_i = 1'b1;
        data_in_i  = 8'h80;
        @(posedge clk_i);
        #1;
        valid_in_i = 1'b0;
        check_eq("post_rst_valid",  {31'd0, valid_out_o}, 32'd1);
        check_eq("post_rst_data",   {24'd0, data_out_o}, 32'h80);
        check_eq("post_rst_parity", {28'd0, parity_bits_o}, 32'hC);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
